// File: rtl/bound_flasher_fsm_if.sv
// rtl/bound_flasher_fsm_if.sv - flick request in, state/lamp bar/tick out of the bound flasher sequencer
interface bound_flasher_fsm_if;
  logic        flick;
  logic [2:0]  current;
  logic [4:0]  lamp_cnt;
  logic [15:0] lamps;
  logic        tick;

  modport master (
    output flick,
    input  current,
    input  lamp_cnt,
    input  lamps,
    input  tick
  );

  modport slave (
    input  flick,
    output current,
    output lamp_cnt,
    output lamps,
    output tick
  );
endinterface

// File: rtl/bound_flasher_fsm.sv
// rtl/bound_flasher_fsm.sv - 7-state bound flasher sequencer with 16-lamp thermometer bar
// Optional BF_FLICK_LATCH_EN: flick pulses between step ticks are held until the next tick.
module bound_flasher_fsm #(
  parameter int STEP_DIV = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  bound_flasher_fsm_if.slave bus
);

  localparam int            PW        = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(STEP_DIV - 1);

  typedef enum logic [2:0] {
    S0_IDLE  = 3'd0,
    S1_UP16  = 3'd1,
    S2_DN5   = 3'd2,
    S3_UP11  = 3'd3,
    S4_DN0   = 3'd4,
    S5_UP6   = 3'd5,
    S6_DN0   = 3'd6
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [4:0]    r_lamp_cnt;
  logic [4:0]    w_lamp_cnt_next;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_next;
  logic          r_tick;
  logic          w_step;
  logic          w_flick;
  logic          w_kick_pt;
  logic [15:0]   w_lamps;

  assign w_step       = (r_presc == PRESC_MAX);
  assign w_presc_next = w_step ? '0 : r_presc + PW'(1);
  assign w_kick_pt    = (r_lamp_cnt == 5'd6) || (r_lamp_cnt == 5'd11);

`ifdef BF_FLICK_LATCH_EN
  logic r_flick_flag;

  // The flag is consumed by the tick that samples it, so it clears on every step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flick_flag <= 1'b0;
    end else if (w_step) begin
      r_flick_flag <= 1'b0;
    end else if (bus.flick) begin
      r_flick_flag <= 1'b1;
    end
  end

  assign w_flick = bus.flick | r_flick_flag;
`else
  assign w_flick = bus.flick;
`endif

  // r_tick announces that the coming clock edge is a step edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S0_IDLE;
      r_lamp_cnt <= '0;
      r_presc    <= '0;
      r_tick     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_lamp_cnt <= w_lamp_cnt_next;
      r_presc    <= w_presc_next;
      r_tick     <= (w_presc_next == PRESC_MAX);
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_lamp_cnt_next = r_lamp_cnt;
    if (r_state > S6_DN0) begin
      w_state_next    = S0_IDLE;
      w_lamp_cnt_next = '0;
    end else if (w_step) begin
      case (r_state)
        S0_IDLE: begin
          if (w_flick) w_state_next = S1_UP16;
        end
        S1_UP16: begin
          if (w_flick && w_kick_pt)        w_state_next    = S2_DN5;
          else if (r_lamp_cnt == 5'd16)    w_state_next    = S2_DN5;
          else                             w_lamp_cnt_next = r_lamp_cnt + 5'd1;
        end
        S2_DN5: begin
          if (r_lamp_cnt == 5'd5)          w_state_next    = S3_UP11;
          else                             w_lamp_cnt_next = r_lamp_cnt - 5'd1;
        end
        S3_UP11: begin
          // Kickback at 11 wins over the normal exit to S4.
          if (w_flick && w_kick_pt)        w_state_next    = S2_DN5;
          else if (r_lamp_cnt == 5'd11)    w_state_next    = S4_DN0;
          else                             w_lamp_cnt_next = r_lamp_cnt + 5'd1;
        end
        S4_DN0: begin
          if (r_lamp_cnt == 5'd0)          w_state_next    = S5_UP6;
          else                             w_lamp_cnt_next = r_lamp_cnt - 5'd1;
        end
        S5_UP6: begin
          if (r_lamp_cnt == 5'd6)          w_state_next    = S6_DN0;
          else                             w_lamp_cnt_next = r_lamp_cnt + 5'd1;
        end
        S6_DN0: begin
          if (r_lamp_cnt == 5'd0)          w_state_next    = S0_IDLE;
          else                             w_lamp_cnt_next = r_lamp_cnt - 5'd1;
        end
        default: begin
          w_state_next    = S0_IDLE;
          w_lamp_cnt_next = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_lamps = '0;
    for (int i = 0; i < 16; i++) begin
      w_lamps[i] = (5'(i) < r_lamp_cnt);
    end
  end

  assign bus.current  = r_state;
  assign bus.lamp_cnt = r_lamp_cnt;
  assign bus.lamps    = w_lamps;
  assign bus.tick     = r_tick;

endmodule

// File: tb/tb_bound_flasher_fsm.sv
// tb/tb_bound_flasher_fsm.sv - scoreboard bench for bound_flasher_fsm at STEP_DIV 1 and 4
module tb_bound_flasher_fsm;

  typedef struct packed {
    logic [2:0]  cur;
    logic [4:0]  cnt;
    logic [15:0] lamps;
    logic        tick;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   edge_cnt;
  int   base;

  bound_flasher_fsm_if io0();
  bound_flasher_fsm_if io1();

  bound_flasher_fsm #(.STEP_DIV(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(io0));
  bound_flasher_fsm #(.STEP_DIV(4)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(io1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each lighting/dimming phase walks toward a target, then moves to the next phase.
  int   div_c[2]  = '{1, 4};
  int   target[7] = '{0, 16, 5, 11, 0, 6, 0};
  int   m_state[2];
  int   m_cnt[2];
  int   m_edges[2];
  bit   m_flag[2];
  exp_t q0[$];
  exp_t q1[$];
  exp_t sb_e;

  function automatic void model_reset(int i);
    m_state[i] = 0;
    m_cnt[i]   = 0;
    m_edges[i] = 0;
    m_flag[i]  = 1'b0;
  endfunction

  function automatic void model_step(int i, bit f);
    bit en;
    bit eff;
    m_edges[i]++;
    en  = (m_edges[i] % div_c[i]) == 0;
    eff = f;
`ifdef BF_FLICK_LATCH_EN
    eff = f | m_flag[i];
    m_flag[i] = en ? 1'b0 : (m_flag[i] | f);
`endif
    if (en) begin
      if (m_state[i] == 0) begin
        if (eff) m_state[i] = 1;
      end else if ((m_state[i] == 1 || m_state[i] == 3) && eff && (m_cnt[i] == 6 || m_cnt[i] == 11)) begin
        m_state[i] = 2;
      end else if (m_cnt[i] == target[m_state[i]]) begin
        m_state[i] = (m_state[i] + 1) % 7;
      end else begin
        m_cnt[i] += (m_state[i] % 2 == 1) ? 1 : -1;
      end
    end
  endfunction

  function automatic exp_t model_expect(int i);
    exp_t e;
    e.cur   = 3'(m_state[i]);
    e.cnt   = 5'(m_cnt[i]);
    e.lamps = '0;
    for (int k = 0; k < 16; k++) e.lamps[k] = (k < m_cnt[i]);
    e.tick  = ((m_edges[i] + 1) % div_c[i]) == 0;
    return e;
  endfunction

  always @(negedge rst_n) begin
    model_reset(0);
    model_reset(1);
  end

  always @(posedge clk) begin
    edge_cnt++;
    if (!rst_n) begin
      model_reset(0);
      model_reset(1);
      q0.push_back('0);
      q1.push_back('0);
    end else begin
      model_step(0, io0.flick);
      model_step(1, io1.flick);
      q0.push_back(model_expect(0));
      q1.push_back(model_expect(1));
    end
  end

  always @(negedge clk) begin
    while (q0.size() > 0) begin
      sb_e = q0.pop_front();
      checks++;
      if ({io0.current, io0.lamp_cnt, io0.lamps, io0.tick} !== sb_e) begin
        errors++;
        $display("FAIL sb_div1 t=%0t actual cur=%0d cnt=%0d lamps=%h tick=%b required cur=%0d cnt=%0d lamps=%h tick=%b",
                 $time, io0.current, io0.lamp_cnt, io0.lamps, io0.tick, sb_e.cur, sb_e.cnt, sb_e.lamps, sb_e.tick);
      end
    end
    while (q1.size() > 0) begin
      sb_e = q1.pop_front();
      checks++;
      if ({io1.current, io1.lamp_cnt, io1.lamps, io1.tick} !== sb_e) begin
        errors++;
        $display("FAIL sb_div4 t=%0t actual cur=%0d cnt=%0d lamps=%h tick=%b required cur=%0d cnt=%0d lamps=%h tick=%b",
                 $time, io1.current, io1.lamp_cnt, io1.lamps, io1.tick, sb_e.cur, sb_e.cnt, sb_e.lamps, sb_e.tick);
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  task automatic start0();
    io0.flick = 1'b1;
    base      = edge_cnt + 1;
    @(negedge clk);
    io0.flick = 1'b0;
  endtask

  task automatic at_edge(int k);
    while (edge_cnt < base + k) @(negedge clk);
  endtask

  task automatic wait_tick1();
    int k = 0;
    while (io1.tick !== 1'b1 && k < 16) begin
      @(negedge clk);
      k++;
    end
    if (k >= 16) begin
      checks++;
      errors++;
      $display("FAIL wait_tick timeout actual=0 required=1");
    end
  endtask

  task automatic wait_idle0();
    int k = 0;
    while (io0.current !== 3'd0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_idle timeout actual=%0d required=0", io0.current);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int  hi;
    bit  prev;
    bit  dbl;
    checks    = 0;
    errors    = 0;
    edge_cnt  = 0;
    base      = 0;
    rst_n     = 1'b0;
    io0.flick = 1'b0;
    io1.flick = 1'b0;
    #2;
    chk("rst_current", 32'(io0.current), 0);
    chk("rst_lamp_cnt", 32'(io0.lamp_cnt), 0);
    chk("rst_lamps", 32'(io0.lamps), 0);
    chk("rst_tick", 32'(io0.tick), 0);
    chk("rst_div4_tick", 32'(io1.tick), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    start0();
    at_edge(16); chk("nom_e16_cur", 32'(io0.current), 1);
                 chk("nom_e16_cnt", 32'(io0.lamp_cnt), 16);
                 chk("nom_e16_lamps", 32'(io0.lamps), 32'hFFFF);
    at_edge(17); chk("nom_e17_cur", 32'(io0.current), 2);
    at_edge(28); chk("nom_e28_cnt", 32'(io0.lamp_cnt), 5);
                 chk("nom_e28_lamps", 32'(io0.lamps), 32'h001F);
    at_edge(36); chk("nom_e36_cur", 32'(io0.current), 4);
    at_edge(48); chk("nom_e48_cur", 32'(io0.current), 5);
    at_edge(55); chk("nom_e55_cur", 32'(io0.current), 6);
    at_edge(61); chk("nom_e61_cur", 32'(io0.current), 6);
    at_edge(62); chk("nom_e62_cur", 32'(io0.current), 0);
                 chk("nom_e62_cnt", 32'(io0.lamp_cnt), 0);
    repeat (3) @(negedge clk);

    start0();
    at_edge(6);  io0.flick = 1'b1;
    at_edge(7);  chk("kb1_cur", 32'(io0.current), 2);
                 chk("kb1_cnt", 32'(io0.lamp_cnt), 6);
                 io0.flick = 1'b0;
    at_edge(8);  chk("kb1_dim_cnt", 32'(io0.lamp_cnt), 5);
    at_edge(9);  chk("kb1_s3_cur", 32'(io0.current), 3);
    at_edge(15); chk("kb3_pre_cnt", 32'(io0.lamp_cnt), 11);
                 io0.flick = 1'b1;
    at_edge(16); chk("kb3_cur", 32'(io0.current), 2);
                 chk("kb3_cnt", 32'(io0.lamp_cnt), 11);
                 io0.flick = 1'b0;
    at_edge(48); chk("s5_pre_cnt", 32'(io0.lamp_cnt), 6);
                 io0.flick = 1'b1;
    at_edge(49); chk("s5_nokick_cur", 32'(io0.current), 6);
    at_edge(56); chk("restart_s0_cur", 32'(io0.current), 0);
    at_edge(57); chk("restart_s1_cur", 32'(io0.current), 1);
                 io0.flick = 1'b0;
    wait_idle0();
    repeat (2) @(negedge clk);

    start0();
    at_edge(24); chk("mid_pre_cur", 32'(io0.current), 2);
                 chk("mid_pre_cnt", 32'(io0.lamp_cnt), 9);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cur", 32'(io0.current), 0);
    chk("mid_rst_cnt", 32'(io0.lamp_cnt), 0);
    chk("mid_rst_lamps", 32'(io0.lamps), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    wait_tick1();
    @(negedge clk);
    io1.flick = 1'b1;
    @(negedge clk);
    io1.flick = 1'b0;
    chk("div4_nontick_hold", 32'(io1.current), 0);
    wait_tick1();
    @(negedge clk);
`ifdef BF_FLICK_LATCH_EN
    chk("div4_latched_pulse", 32'(io1.current), 1);
`else
    chk("div4_dropped_pulse", 32'(io1.current), 0);
    wait_tick1();
    io1.flick = 1'b1;
    @(negedge clk);
    io1.flick = 1'b0;
    chk("div4_start_cur", 32'(io1.current), 1);
`endif
    chk("div4_start_cnt", 32'(io1.lamp_cnt), 0);
    repeat (3) begin
      @(negedge clk);
      chk("div4_between_ticks_cnt", 32'(io1.lamp_cnt), 0);
    end
    @(negedge clk);
    chk("div4_step_cnt", 32'(io1.lamp_cnt), 1);
    hi   = 0;
    prev = 1'b0;
    dbl  = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (io1.tick) hi++;
      if (io1.tick && prev) dbl = 1'b1;
      prev = io1.tick;
    end
    chk("div4_tick_count", 32'(hi), 2);
    chk("div4_tick_width", 32'(dbl), 0);

    repeat (1500) begin
      @(negedge clk);
      io0.flick = ($urandom_range(0, 5) == 0);
      io1.flick = ($urandom_range(0, 2) == 0);
    end
    io0.flick = 1'b0;
    io1.flick = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
